// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates tags at dispatch, gathers CDB results and store
// data, answers operand lookups, and retires in program order with a store handshake and flush.
module reorder_buffer #(
  parameter int ROB_WIDTH = 4,
  parameter int XLEN      = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 dispatcher_rob_en_in,
  input  logic [1:0]           dispatcher_rob_type_in,
  input  logic [4:0]           dispatcher_rob_rd_in,
  output logic [ROB_WIDTH-1:0] rob_dispatcher_tag_out,
  output logic                 rob_dispatcher_rdy_out,
  input  logic [ROB_WIDTH-1:0] dispatcher_rob_q1_in,
  input  logic [ROB_WIDTH-1:0] dispatcher_rob_q2_in,
  output logic                 rob_dispatcher_ready1_out,
  output logic                 rob_dispatcher_ready2_out,
  output logic [XLEN-1:0]      rob_dispatcher_value1_out,
  output logic [XLEN-1:0]      rob_dispatcher_value2_out,
  input  logic                 cdb_rob_en_in,
  input  logic [ROB_WIDTH-1:0] cdb_rob_b_in,
  input  logic [XLEN-1:0]      cdb_rob_result_in,
  input  logic                 cdb_rob_jump_in,
  input  logic [XLEN-1:0]      cdb_rob_target_in,
  input  logic [ROB_WIDTH-1:0] rs_rob_h_in,
  input  logic [XLEN-1:0]      rs_rob_value_in,
  output logic                 rob_regfile_en_out,
  output logic [4:0]           rob_regfile_rd_out,
  output logic [ROB_WIDTH-1:0] rob_regfile_tag_out,
  output logic [XLEN-1:0]      rob_regfile_value_out,
  output logic                 rob_lsb_commit_out,
  output logic [ROB_WIDTH-1:0] rob_lsb_tag_out,
  input  logic                 lsb_rob_done_in,
  output logic                 rob_rst_out,
  output logic [XLEN-1:0]      rob_pc_out
);

  localparam int unsigned DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH-1:0] TAG_ONE  = ROB_WIDTH'(1);
  localparam logic [ROB_WIDTH-1:0] TAG_LAST = '1;

  typedef enum logic [1:0] {TY_REG = 2'd0, TY_STORE = 2'd1, TY_BRANCH = 2'd2} rob_type_e;
  typedef enum logic {S_IDLE = 1'b0, S_STORE_WAIT = 1'b1} state_e;

  state_e               state, state_nxt;
  logic [ROB_WIDTH-1:0] head, tail, count;

  // Slot 0 exists only so tags index directly; it is never allocated.
  logic            ent_valid  [DEPTH];
  logic            ent_ready  [DEPTH];
  logic [1:0]      ent_type   [DEPTH];
  logic [4:0]      ent_rd     [DEPTH];
  logic [XLEN-1:0] ent_value  [DEPTH];
  logic            ent_jump   [DEPTH];
  logic [XLEN-1:0] ent_target [DEPTH];

  logic head_ready, commit_rf, start_store, store_retire, retire, flush, alloc;

  function automatic logic [ROB_WIDTH-1:0] next_ptr(input logic [ROB_WIDTH-1:0] p);
    return (p == TAG_LAST) ? TAG_ONE : p + TAG_ONE;
  endfunction

  assign rob_dispatcher_tag_out = tail;
  assign rob_dispatcher_rdy_out = (count != TAG_LAST);

  always_comb begin
    head_ready   = ent_valid[head] && ent_ready[head];
    commit_rf    = 1'b0;
    start_store  = 1'b0;
    store_retire = 1'b0;
    flush        = 1'b0;
    state_nxt    = state;
    case (state)
      S_IDLE: begin
        if (head_ready) begin
          if (ent_type[head] == TY_STORE) begin
            start_store = 1'b1;
            state_nxt   = S_STORE_WAIT;
          end else begin
            commit_rf = 1'b1;
            flush     = (ent_type[head] == TY_BRANCH) && ent_jump[head];
          end
        end
      end
      S_STORE_WAIT: begin
        if (lsb_rob_done_in) begin
          store_retire = 1'b1;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    retire = commit_rf || store_retire;
    alloc  = dispatcher_rob_en_in && (count != TAG_LAST) && !flush;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)   state <= S_IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head                  <= TAG_ONE;
      tail                  <= TAG_ONE;
      count                 <= '0;
      rob_regfile_en_out    <= 1'b0;
      rob_regfile_rd_out    <= '0;
      rob_regfile_tag_out   <= '0;
      rob_regfile_value_out <= '0;
      rob_lsb_commit_out    <= 1'b0;
      rob_lsb_tag_out       <= '0;
      rob_rst_out           <= 1'b0;
      rob_pc_out            <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_valid[i]  <= 1'b0;
        ent_ready[i]  <= 1'b0;
        ent_type[i]   <= '0;
        ent_rd[i]     <= '0;
        ent_value[i]  <= '0;
        ent_jump[i]   <= 1'b0;
        ent_target[i] <= '0;
      end
    end else begin
      rob_regfile_en_out <= 1'b0;
      rob_rst_out        <= 1'b0;
      if (rdy_in) begin
        if (commit_rf) begin
          rob_regfile_en_out    <= (ent_rd[head] != 5'd0);
          rob_regfile_rd_out    <= ent_rd[head];
          rob_regfile_tag_out   <= head;
          rob_regfile_value_out <= ent_value[head];
        end
        if (flush) begin
          rob_rst_out        <= 1'b1;
          rob_pc_out         <= ent_target[head];
          rob_lsb_commit_out <= 1'b0;
          head               <= TAG_ONE;
          tail               <= TAG_ONE;
          count              <= '0;
          for (int unsigned i = 0; i < DEPTH; i++) ent_valid[i] <= 1'b0;
        end else begin
          if (alloc) begin
            ent_valid[tail] <= 1'b1;
            ent_ready[tail] <= 1'b0;
            ent_type[tail]  <= dispatcher_rob_type_in;
            ent_rd[tail]    <= dispatcher_rob_rd_in;
            ent_jump[tail]  <= 1'b0;
            tail            <= next_ptr(tail);
          end
          if (cdb_rob_en_in && ent_valid[cdb_rob_b_in]) begin
            ent_ready[cdb_rob_b_in]  <= 1'b1;
            ent_value[cdb_rob_b_in]  <= cdb_rob_result_in;
            ent_jump[cdb_rob_b_in]   <= cdb_rob_jump_in;
            ent_target[cdb_rob_b_in] <= cdb_rob_target_in;
          end
          if (rs_rob_h_in != '0 && ent_valid[rs_rob_h_in] && ent_type[rs_rob_h_in] == TY_STORE) begin
            ent_ready[rs_rob_h_in] <= 1'b1;
            ent_value[rs_rob_h_in] <= rs_rob_value_in;
          end
          if (start_store) begin
            rob_lsb_commit_out <= 1'b1;
            rob_lsb_tag_out    <= head;
          end
          if (store_retire) rob_lsb_commit_out <= 1'b0;
          // Placed after the result writes so retirement's valid-clear wins on the head slot.
          if (retire) begin
            ent_valid[head] <= 1'b0;
            head            <= next_ptr(head);
          end
          case ({alloc, retire})
            2'b10:   count <= count + TAG_ONE;
            2'b01:   count <= count - TAG_ONE;
            default: count <= count;
          endcase
        end
      end
    end
  end

  always_comb begin
    rob_dispatcher_ready1_out = 1'b0;
    rob_dispatcher_value1_out = '0;
    if (dispatcher_rob_q1_in != '0) begin
      if (cdb_rob_en_in && cdb_rob_b_in == dispatcher_rob_q1_in) begin
        rob_dispatcher_ready1_out = 1'b1;
        rob_dispatcher_value1_out = cdb_rob_result_in;
      end else if (ent_valid[dispatcher_rob_q1_in] && ent_ready[dispatcher_rob_q1_in]) begin
        rob_dispatcher_ready1_out = 1'b1;
        rob_dispatcher_value1_out = ent_value[dispatcher_rob_q1_in];
      end
    end
  end

  always_comb begin
    rob_dispatcher_ready2_out = 1'b0;
    rob_dispatcher_value2_out = '0;
    if (dispatcher_rob_q2_in != '0) begin
      if (cdb_rob_en_in && cdb_rob_b_in == dispatcher_rob_q2_in) begin
        rob_dispatcher_ready2_out = 1'b1;
        rob_dispatcher_value2_out = cdb_rob_result_in;
      end else if (ent_valid[dispatcher_rob_q2_in] && ent_ready[dispatcher_rob_q2_in]) begin
        rob_dispatcher_ready2_out = 1'b1;
        rob_dispatcher_value2_out = ent_value[dispatcher_rob_q2_in];
      end
    end
  end

endmodule
